// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
package imem_pkg;

    localparam int unsigned AW_DEF = 9;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic {
        BOOT,
        RUN
    } state_e;

    typedef enum logic {
        OWN_F,
        OWN_L
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the F side is masked by en_f.
module rr_arb2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_f,
    input  logic req_l,
    input  logic en_f,
    output logic gnt_f,
    output logic gnt_l
);

    owner_e last_q;
    logic   act_f;

    always_comb begin
        act_f = req_f & en_f;
        gnt_f = 1'b0;
        gnt_l = 1'b0;
        if (act_f && req_l) begin
            // Contention: the side that did not win last time goes first.
            if (last_q == OWN_L) begin
                gnt_f = 1'b1;
            end else begin
                gnt_l = 1'b1;
            end
        end else begin
            gnt_f = act_f;
            gnt_l = req_l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_L;
        end else if (gnt_f) begin
            last_q <= OWN_F;
        end else if (gnt_l) begin
            last_q <= OWN_L;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port synchronous instruction memory between fetch (F) and loader (L),
// holding fetch off until the loader signals the program is in place.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          boot_done,
    output logic          running,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e state_q, state_d;
    logic   rd_pend_q;
    owner_e rd_own_q;

    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && boot_done) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    assign running = (state_q == RUN);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_f (f_req),
        .req_l (l_req),
        .en_f  (running),
        .gnt_f (f_gnt),
        .gnt_l (l_gnt)
    );

    always_comb begin
        mem_en    = f_gnt | l_gnt;
        mem_we    = l_gnt & l_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
        end
    end

    // Tag each read with its owner so the returning data goes to the right requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_own_q  <= OWN_L;
        end else begin
            rd_pend_q <= f_gnt | (l_gnt & ~l_we);
            rd_own_q  <= f_gnt ? OWN_F : OWN_L;
        end
    end

    assign f_rvalid = rd_pend_q && (rd_own_q == OWN_F);
    assign l_rvalid = rd_pend_q && (rd_own_q == OWN_L);
    assign f_rdata  = mem_rdata;
    assign l_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural single-port synchronous memory.
module tb_imem_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          boot_done;
    logic          running;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [2**AW];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    imem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_done (boot_done),
        .running   (running),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lw,
                         input logic [AW-1:0] la, input logic [DW-1:0] ld, input logic bd);
        @(negedge clk);
        f_req     = fr;
        f_addr    = fa;
        l_req     = lr;
        l_we      = lw;
        l_addr    = la;
        l_wdata   = ld;
        boot_done = bd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        chk("rst_running", running, 0);
        chk("rst_f_rvalid", f_rvalid, 0);
        chk("rst_l_rvalid", l_rvalid, 0);
        chk("rst_f_gnt", f_gnt, 0);
        chk("rst_l_gnt", l_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);

        @(negedge clk);
        rst = 1'b0;

        // Boot load: L writes while F asks in vain; boot_done on the last write.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, '0, 1'b1, 1'b1, AW'(i), 32'h0000_0013, (i == 3));
            chk("boot_f_gnt", f_gnt, 0);
            chk("boot_l_gnt", l_gnt, 1);
            chk("boot_mem_we", mem_we, 1);
            chk("boot_mem_addr", mem_addr, i);
            chk("boot_running", running, 0);
            tick();
            chk("boot_l_rvalid", l_rvalid, 0);
        end
        chk("boot_to_run", running, 1);

        // Fetch read.
        drive(1'b1, 9'd2, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("fetch_f_gnt", f_gnt, 1);
        chk("fetch_l_gnt", l_gnt, 0);
        chk("fetch_mem_addr", mem_addr, 2);
        chk("fetch_mem_we", mem_we, 0);
        tick();
        chk("fetch_f_rvalid", f_rvalid, 1);
        chk("fetch_f_rdata", f_rdata, 32'h0000_0013);
        chk("fetch_l_rvalid", l_rvalid, 0);

        // Loader read so that L is last winner before contention.
        drive(1'b0, '0, 1'b1, 1'b0, 9'd1, '0, 1'b0);
        chk("lrd_l_gnt", l_gnt, 1);
        chk("lrd_f_rvalid_prev_done", f_rvalid, 1);
        tick();
        chk("lrd_l_rvalid", l_rvalid, 1);
        chk("lrd_f_rvalid", f_rvalid, 0);
        chk("lrd_l_rdata", l_rdata, 32'h0000_0013);

        // Contention: grants alternate F,L,F,L,F,L.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 9'd0, 1'b1, 1'b0, 9'd3, '0, 1'b0);
            chk("cont_f_gnt", f_gnt, (k % 2 == 0));
            chk("cont_l_gnt", l_gnt, (k % 2 == 1));
            chk("cont_mem_addr", mem_addr, (k % 2 == 0) ? 0 : 3);
            tick();
            chk("cont_f_rvalid", f_rvalid, (k % 2 == 0));
            chk("cont_l_rvalid", l_rvalid, (k % 2 == 1));
            chk("cont_rdata", f_rdata, 32'h0000_0013);
        end

        // Idle: memory bus quiet.
        drive(1'b0, 9'h1ff, 1'b0, 1'b0, 9'h1ff, 32'hffff_ffff, 1'b0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_mem_wdata", mem_wdata, 0);
        tick();
        chk("idle_f_rvalid", f_rvalid, 0);
        chk("idle_l_rvalid", l_rvalid, 0);

        // Loader write in RUN, then F reads it back.
        drive(1'b0, '0, 1'b1, 1'b1, 9'd5, 32'hdead_beef, 1'b0);
        chk("lwr_l_gnt", l_gnt, 1);
        chk("lwr_mem_we", mem_we, 1);
        chk("lwr_mem_wdata", mem_wdata, 32'hdead_beef);
        chk("lwr_mem_addr", mem_addr, 5);
        tick();
        chk("lwr_l_rvalid", l_rvalid, 0);
        drive(1'b1, 9'd5, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("fwr_f_gnt", f_gnt, 1);
        tick();
        chk("fwr_f_rvalid", f_rvalid, 1);
        chk("fwr_f_rdata", f_rdata, 32'hdead_beef);

        // Late boot_done: ignored; F won last so L goes first.
        drive(1'b1, 9'd5, 1'b1, 1'b0, 9'd5, '0, 1'b1);
        chk("late_l_gnt", l_gnt, 1);
        chk("late_f_gnt", f_gnt, 0);
        tick();
        chk("late_running", running, 1);
        chk("late_l_rvalid", l_rvalid, 1);
        chk("late_l_rdata", l_rdata, 32'hdead_beef);
        drive(1'b1, 9'd5, 1'b1, 1'b0, 9'd5, '0, 1'b0);
        chk("late2_f_gnt", f_gnt, 1);
        tick();
        chk("late2_f_rvalid", f_rvalid, 1);

        // Reset mid-read: grant in N, reset in N+1.
        drive(1'b1, 9'd2, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("mid_f_gnt", f_gnt, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("mid_f_rvalid", f_rvalid, 0);
        chk("mid_running", running, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_after_f_gnt", f_gnt, 0);
        chk("mid_after_mem_en", mem_en, 0);
        tick();
        chk("mid_after_f_rvalid", f_rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
